// File: rtl/status_flag_register.sv
// status_flag_register
//
// Architectural NZCV status register. It computes the condition flags from
// execute-stage ALU results, holds them across instructions, and keeps one
// saved copy for exception entry and return.
//
// Optional feature macro: STATUS_FORWARD_EN
//   When defined, a flag update in the current cycle is forwarded to `status`
//   combinationally. Register contents are the same in both builds.
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   synchronous active-low reset
//   valid          in   execute-stage instruction valid
//   s_bit          in   instruction requests a flag update
//   stall          in   pipeline hold, blocks all state changes
//   flush          in   squash, blocks update/save/restore
//   flag_mode      in   00 logical, 01 arithmetic, 10 explicit, 11 restore
//   alu_result     in   ALU result, N taken from the MSB
//   alu_carry      in   adder carry (arith) / shifter carry (logical)
//   alu_ovf        in   signed overflow from the adder
//   wr_flags       in   explicit {N,Z,C,V} for mode 10
//   save           in   copy current flags into the saved copy
//   status         out  {N,Z,C,V} to condition check
//   saved_status   out  saved {N,Z,C,V}
//   flags_written  out  registered pulse, flags updated in the previous cycle
module status_flag_register #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              s_bit,
  input  logic              stall,
  input  logic              flush,
  input  logic [1:0]        flag_mode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_ovf,
  input  logic [3:0]        wr_flags,
  input  logic              save,
  output logic [3:0]        status,
  output logic [3:0]        saved_status,
  output logic              flags_written
);

  localparam logic [1:0] ModeLogical  = 2'b00;
  localparam logic [1:0] ModeArith    = 2'b01;
  localparam logic [1:0] ModeExplicit = 2'b10;
  localparam logic [1:0] ModeRestore  = 2'b11;

  logic [3:0] status_q, status_d;
  logic [3:0] saved_q, saved_d;
  logic       flags_written_q, flags_written_d;

  logic       upd;
  logic       act_save;
  logic       res_n;
  logic       res_z;
  logic [3:0] nf;

  assign upd      = valid & s_bit & ~stall & ~flush;
  assign act_save = save & ~stall & ~flush;

  assign res_n = alu_result[DATA_W-1];
  assign res_z = (alu_result == '0);

  always_comb begin
    nf = status_q;
    unique case (flag_mode)
      ModeLogical:  nf = {res_n, res_z, alu_carry, status_q[0]};  // V is held
      ModeArith:    nf = {res_n, res_z, alu_carry, alu_ovf};
      ModeExplicit: nf = wr_flags;
      ModeRestore:  nf = saved_q;
      default:      nf = status_q;
    endcase
  end

  always_comb begin
    status_d        = upd ? nf : status_q;
    // Saved copy always takes the pre-update value; restore+save swaps.
    saved_d         = act_save ? status_q : saved_q;
    flags_written_d = upd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_q        <= 4'b0000;
      saved_q         <= 4'b0000;
      flags_written_q <= 1'b0;
    end else begin
      status_q        <= status_d;
      saved_q         <= saved_d;
      flags_written_q <= flags_written_d;
    end
  end

`ifdef STATUS_FORWARD_EN
  assign status = upd ? nf : status_q;
`else
  assign status = status_q;
`endif

  assign saved_status  = saved_q;
  assign flags_written = flags_written_q;

endmodule

// File: tb/tb_status_flag_register.sv
module tb_status_flag_register;

  localparam int unsigned DataW = 32;
`ifdef STATUS_FORWARD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             valid;
  logic             s_bit;
  logic             stall;
  logic             flush;
  logic [1:0]       flag_mode;
  logic [DataW-1:0] alu_result;
  logic             alu_carry;
  logic             alu_ovf;
  logic [3:0]       wr_flags;
  logic             save;
  logic [3:0]       status;
  logic [3:0]       saved_status;
  logic             flags_written;

  int checks = 0;
  int errors = 0;

  status_flag_register #(.DATA_W(DataW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid        (valid),
    .s_bit        (s_bit),
    .stall        (stall),
    .flush        (flush),
    .flag_mode    (flag_mode),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_ovf      (alu_ovf),
    .wr_flags     (wr_flags),
    .save         (save),
    .status       (status),
    .saved_status (saved_status),
    .flags_written(flags_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst_n;
    logic             valid;
    logic             s_bit;
    logic             stall;
    logic             flush;
    logic             save;
    logic [1:0]       mode;
    logic [DataW-1:0] res;
    logic             carry;
    logic             ovf;
    logic [3:0]       wr;
    logic [3:0]       exp_status;
    logic [3:0]       exp_saved;
    logic             exp_fw;
  } vec_t;

  localparam int NumVec = 19;
  vec_t tbl[NumVec];

  function automatic vec_t mk(logic r, logic v, logic s, logic st, logic fl, logic sv,
                              logic [1:0] m, logic [DataW-1:0] res, logic c, logic o,
                              logic [3:0] wr, logic [3:0] es, logic [3:0] esv, logic efw);
    vec_t t;
    t.rst_n = r; t.valid = v; t.s_bit = s; t.stall = st; t.flush = fl; t.save = sv;
    t.mode = m; t.res = res; t.carry = c; t.ovf = o; t.wr = wr;
    t.exp_status = es; t.exp_saved = esv; t.exp_fw = efw;
    return t;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    rst_n = 1'b1; valid = 1'b0; s_bit = 1'b0; stall = 1'b0; flush = 1'b0; save = 1'b0;
    flag_mode = 2'b00; alu_result = '0; alu_carry = 1'b0; alu_ovf = 1'b0; wr_flags = 4'b0;
  endtask

  task automatic drive_vec(input vec_t t);
    rst_n = t.rst_n; valid = t.valid; s_bit = t.s_bit; stall = t.stall; flush = t.flush;
    save = t.save; flag_mode = t.mode; alu_result = t.res; alu_carry = t.carry;
    alu_ovf = t.ovf; wr_flags = t.wr;
  endtask

  // Reference model state
  logic [3:0] m_flags, m_saved;
  logic       m_fw;

  function automatic logic [3:0] model_nf();
    logic n, z;
    n = (alu_result >> (DataW - 1)) != 0;
    z = (alu_result == 0);
    case (flag_mode)
      2'd0:    return {n, z, alu_carry, m_flags[0]};
      2'd1:    return {n, z, alu_carry, alu_ovf};
      2'd2:    return wr_flags;
      default: return m_saved;
    endcase
  endfunction

  function automatic logic model_upd();
    return valid && s_bit && !stall && !flush;
  endfunction

  initial begin
    // rst, v, s, stall, flush, save, mode, res, c, o, wr, exp status, exp saved, exp fw
    tbl[0]  = mk(0, 1, 1, 0, 0, 1, 2'b10, 32'h0, 0, 0, 4'b1111, 4'b0000, 4'b0000, 0);
    tbl[1]  = mk(0, 1, 1, 0, 0, 1, 2'b10, 32'h0, 0, 0, 4'b1111, 4'b0000, 4'b0000, 0);
    tbl[2]  = mk(1, 1, 1, 0, 0, 0, 2'b01, 32'h0, 1, 1, 4'b0000, 4'b0111, 4'b0000, 1);
    tbl[3]  = mk(1, 1, 1, 0, 0, 0, 2'b01, 32'h8000_0000, 0, 0, 4'b0000, 4'b1000, 4'b0000, 1);
    tbl[4]  = mk(1, 1, 1, 0, 0, 0, 2'b10, 32'h0, 0, 0, 4'b0001, 4'b0001, 4'b0000, 1);
    tbl[5]  = mk(1, 1, 1, 0, 0, 0, 2'b00, 32'h1, 1, 0, 4'b0000, 4'b0011, 4'b0000, 1);
    tbl[6]  = mk(1, 1, 0, 0, 0, 0, 2'b01, 32'h0, 1, 1, 4'b0000, 4'b0011, 4'b0000, 0);
    tbl[7]  = mk(1, 1, 1, 1, 0, 0, 2'b10, 32'h0, 0, 0, 4'b1010, 4'b0011, 4'b0000, 0);
    tbl[8]  = mk(1, 1, 1, 1, 0, 0, 2'b10, 32'h0, 0, 0, 4'b1010, 4'b0011, 4'b0000, 0);
    tbl[9]  = mk(1, 1, 1, 1, 0, 0, 2'b10, 32'h0, 0, 0, 4'b1010, 4'b0011, 4'b0000, 0);
    tbl[10] = mk(1, 1, 1, 0, 0, 0, 2'b10, 32'h0, 0, 0, 4'b1010, 4'b1010, 4'b0000, 1);
    tbl[11] = mk(1, 1, 1, 0, 1, 1, 2'b10, 32'h0, 0, 0, 4'b0110, 4'b1010, 4'b0000, 0);
    tbl[12] = mk(1, 0, 0, 0, 0, 1, 2'b00, 32'h0, 0, 0, 4'b0000, 4'b1010, 4'b1010, 0);
    tbl[13] = mk(1, 1, 1, 0, 0, 0, 2'b10, 32'h0, 0, 0, 4'b0101, 4'b0101, 4'b1010, 1);
    tbl[14] = mk(1, 1, 1, 0, 0, 1, 2'b11, 32'h0, 0, 0, 4'b0000, 4'b1010, 4'b0101, 1);
    tbl[15] = mk(1, 0, 1, 0, 0, 0, 2'b01, 32'h0, 1, 1, 4'b0000, 4'b1010, 4'b0101, 0);
    tbl[16] = mk(1, 1, 1, 0, 0, 1, 2'b10, 32'h0, 0, 0, 4'b0011, 4'b0011, 4'b1010, 1);
    tbl[17] = mk(1, 1, 1, 1, 0, 1, 2'b10, 32'h0, 0, 0, 4'b1111, 4'b0011, 4'b1010, 0);
    tbl[18] = mk(0, 1, 1, 0, 0, 1, 2'b10, 32'h0, 0, 0, 4'b1111, 4'b0000, 4'b0000, 0);

    drive_idle();
    @(negedge clk);

    // Directed table: each vector occupies one edge, outputs checked with idle inputs.
    for (int i = 0; i < NumVec; i++) begin
      drive_vec(tbl[i]);
      @(posedge clk);
      #1 drive_idle();
      #1;
      chk($sformatf("vec%0d status", i), status, tbl[i].exp_status);
      chk($sformatf("vec%0d saved", i), saved_status, tbl[i].exp_saved);
      chk($sformatf("vec%0d flags_written", i), {3'b0, flags_written}, {3'b0, tbl[i].exp_fw});
    end

    // Same-cycle visibility: forwarded only when the macro is on.
    valid = 1'b1; s_bit = 1'b1; flag_mode = 2'b10; wr_flags = 4'b1100;
    #1 chk("fwd same-cycle status", status, Fwd ? 4'b1100 : 4'b0000);
    chk("fwd saved not forwarded", saved_status, 4'b0000);
    @(posedge clk);
    #1 drive_idle();
    #1 chk("fwd next-cycle status", status, 4'b1100);
    chk("fwd flags_written", {3'b0, flags_written}, 4'b0001);

    // Randomized run against the reference model.
    m_flags = 4'b1100; m_saved = 4'b0000; m_fw = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int r;
      rst_n = ($urandom_range(0, 31) != 0);
      valid = ($urandom_range(0, 3) != 0);
      s_bit = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 5) == 0);
      save  = ($urandom_range(0, 4) == 0);
      flag_mode = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 3);
      alu_result = (r == 0) ? '0 : (r == 1) ? 32'h8000_0000 : $urandom;
      alu_carry = 1'($urandom);
      alu_ovf = 1'($urandom);
      wr_flags = 4'($urandom);
      #1;
      chk("rand status", status, (Fwd && model_upd()) ? model_nf() : m_flags);
      chk("rand saved", saved_status, m_saved);
      chk("rand flags_written", {3'b0, flags_written}, {3'b0, m_fw});
      @(posedge clk);
      if (!rst_n) begin
        m_flags = 4'b0; m_saved = 4'b0; m_fw = 1'b0;
      end else begin
        logic [3:0] nf;
        logic       u;
        nf = model_nf();
        u  = model_upd();
        if (save && !stall && !flush) m_saved = m_flags;
        if (u) m_flags = nf;
        m_fw = u;
      end
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
